// File: rtl/turtle_board_debug_io_pkg.sv
// ----------------------------------------------------------------------------
// turtle_io_pkg
// Shared types and helpers for the board-level debug front end.
//   src_sel_e    : which CPU debug source is shown (REG/DMEM/IMEM/PC)
//   read_state_e : states of the debug read sequencer
//   hex_to_seg   : nibble -> active-low 7-segment pattern {g..a}
// ----------------------------------------------------------------------------
package turtle_io_pkg;

   typedef enum logic [1:0] {
      SRC_REG  = 2'b00,
      SRC_DMEM = 2'b01,
      SRC_IMEM = 2'b10,
      SRC_PC   = 2'b11
   } src_sel_e;

   typedef enum logic [1:0] {
      RD_IDLE    = 2'd0,
      RD_WAIT    = 2'd1,
      RD_CAPTURE = 2'd2
   } read_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/turtle_board_debug_io_if.sv
// ----------------------------------------------------------------------------
// turtle_board_debug_io_if
// CPU debug port bundle between the board debug front end (master) and the
// CPU (slave).
//   debug_enable     master->slave  debug mode request
//   reg_debug_addr   master->slave  register read address
//   reg_debug_rdata  slave->master  register read data
//   dmem_debug_addr  master->slave  data memory read address
//   dmem_debug_rdata slave->master  data memory read data
//   imem_debug_addr  master->slave  instruction memory read address
//   imem_debug_rdata slave->master  instruction memory read data
//   pc               slave->master  current program counter
// ----------------------------------------------------------------------------
interface turtle_board_debug_io_if #(
   parameter int DATA_W     = 8,
   parameter int D_ADDR_W   = 12,
   parameter int INST_W     = 16,
   parameter int I_ADDR_W   = 12,
   parameter int REG_ADDR_W = 4
);
   logic                  debug_enable;
   logic [REG_ADDR_W-1:0] reg_debug_addr;
   logic [DATA_W-1:0]     reg_debug_rdata;
   logic [D_ADDR_W-1:0]   dmem_debug_addr;
   logic [DATA_W-1:0]     dmem_debug_rdata;
   logic [I_ADDR_W-1:0]   imem_debug_addr;
   logic [INST_W-1:0]     imem_debug_rdata;
   logic [I_ADDR_W-1:0]   pc;

   modport master (
      output debug_enable, reg_debug_addr, dmem_debug_addr, imem_debug_addr,
      input  reg_debug_rdata, dmem_debug_rdata, imem_debug_rdata, pc
   );

   modport slave (
      input  debug_enable, reg_debug_addr, dmem_debug_addr, imem_debug_addr,
      output reg_debug_rdata, dmem_debug_rdata, imem_debug_rdata, pc
   );
endinterface

// File: rtl/turtle_board_debug_io_debounce.sv
// ----------------------------------------------------------------------------
// turtle_sw_debounce
// Two-flop synchroniser plus per-bit debounce counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   din  [WIDTH] : raw asynchronous inputs
//   dout [WIDTH] : accepted (debounced) values
// A bit is accepted after its synchronised value has differed from the
// accepted value for CYCLES consecutive cycles; any return to the accepted
// value restarts the count.
// ----------------------------------------------------------------------------
module turtle_sw_debounce #(
   parameter int WIDTH  = 16,
   parameter int CYCLES = 250000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != acc_q[i]) begin
            if (cnt_q[i] == CNT_LAST) acc_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         acc_q   <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         acc_q   <= acc_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign dout = acc_q;

endmodule

// File: rtl/turtle_board_debug_io.sv
// ----------------------------------------------------------------------------
// turtle_board_debug_io
// Board debug front end: debounced switches select a CPU debug source and
// address, a small sequencer reads it (on every selection change and
// periodically), and the result is shown in hex on multiplexed 7-seg digits.
//   clk, reset_n : clock, asynchronous active-low reset
//   sw   [SW_W]  : raw switches {src[1:0], debug_enable, ..., addr}
//   led  [LED_W] : debounced switch echo
//   seg  [7]     : segments {g..a}, active low
//   an   [NUM_DIGITS] : digit enables, active low, one-hot
//   dbg          : CPU debug port bundle (master side)
// Build option: TURTLE_IO_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
// ----------------------------------------------------------------------------
module turtle_board_debug_io
   import turtle_io_pkg::*;
#(
   parameter int DATA_W          = 8,
   parameter int D_ADDR_W        = 12,
   parameter int INST_W          = 16,
   parameter int I_ADDR_W        = 12,
   parameter int REG_ADDR_W      = 4,
   parameter int SW_W            = 16,
   parameter int LED_W           = 16,
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REFRESH_CYCLES  = 100000,
   parameter int SAMPLE_CYCLES   = 1000000,
   parameter int READ_LAT        = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [SW_W-1:0]       sw,
   output logic [LED_W-1:0]      led,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   turtle_board_debug_io_if.master dbg
);
   localparam int A_W    = (D_ADDR_W > I_ADDR_W) ? D_ADDR_W : I_ADDR_W;
   localparam int SEL_W  = 2 + A_W;
   localparam int DISP_W = 4 * NUM_DIGITS;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int SMP_W  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   logic [SW_W-1:0] sw_deb;

   turtle_sw_debounce #(.WIDTH(SW_W), .CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sw),
      .dout    (sw_deb)
   );

   logic [SEL_W-1:0] sel_now;
   assign sel_now = {sw_deb[SW_W-1 -: 2], sw_deb[A_W-1:0]};

   read_state_e           state_q, state_d;
   src_sel_e              src_q, src_d;
   logic [LAT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                  pending_q, pending_d;
   logic [SEL_W-1:0]      sel_last_q, sel_last_d;
   logic [SMP_W-1:0]      smp_cnt_q, smp_cnt_d;
   logic [DISP_W-1:0]     disp_q, disp_d;
   logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [D_ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [I_ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
   logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  trigger;

   // Read sequencer. Addresses follow the switches only while idle so they
   // hold still for the whole read; a trigger during a read sets one
   // pending bit that restarts the sequencer once it is back in IDLE.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      wait_cnt_d  = wait_cnt_q;
      pending_d   = pending_q;
      disp_d      = disp_q;
      reg_addr_d  = reg_addr_q;
      dmem_addr_d = dmem_addr_q;
      imem_addr_d = imem_addr_q;
      sel_last_d  = sel_now;

      smp_cnt_d = (smp_cnt_q == SMP_W'(SAMPLE_CYCLES - 1)) ? '0 : smp_cnt_q + SMP_W'(1);
      trigger   = (sel_now != sel_last_q) || (smp_cnt_q == SMP_W'(SAMPLE_CYCLES - 1));

      unique case (state_q)
         RD_IDLE: begin
            reg_addr_d  = sw_deb[REG_ADDR_W-1:0];
            dmem_addr_d = sw_deb[D_ADDR_W-1:0];
            imem_addr_d = sw_deb[I_ADDR_W-1:0];
            src_d       = src_sel_e'(sw_deb[SW_W-1 -: 2]);
            if (trigger || pending_q) begin
               state_d    = RD_WAIT;
               wait_cnt_d = '0;
               pending_d  = 1'b0;
            end
         end
         RD_WAIT: begin
            if (trigger) pending_d = 1'b1;
            if (wait_cnt_q == LAT_W'(READ_LAT - 1)) state_d = RD_CAPTURE;
            else                                    wait_cnt_d = wait_cnt_q + LAT_W'(1);
         end
         RD_CAPTURE: begin
            if (trigger) pending_d = 1'b1;
            unique case (src_q)
               SRC_REG:  disp_d = DISP_W'(dbg.reg_debug_rdata);
               SRC_DMEM: disp_d = DISP_W'(dbg.dmem_debug_rdata);
               SRC_IMEM: disp_d = DISP_W'(dbg.imem_debug_rdata);
               SRC_PC:   disp_d = DISP_W'(dbg.pc);
            endcase
            state_d = RD_IDLE;
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Digit scanner: an and seg are both derived from the current index and
   // registered together so they switch on the same edge.
   always_comb begin
      ref_cnt_d = ref_cnt_q + REF_W'(1);
      dig_idx_d = dig_idx_q;
      if (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1)) begin
         ref_cnt_d = '0;
         dig_idx_d = (dig_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
      end
      an_d  = ~(NUM_DIGITS'(1) << dig_idx_q);
      seg_d = hex_to_seg(disp_q[{dig_idx_q, 2'b00} +: 4]);
`ifdef TURTLE_IO_ZERO_BLANK_EN
      // Blank when this digit and every more significant one are zero.
      if ((dig_idx_q != '0) && ((disp_q >> {dig_idx_q, 2'b00}) == '0)) seg_d = SEG_BLANK;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RD_IDLE;
         src_q       <= SRC_REG;
         wait_cnt_q  <= '0;
         pending_q   <= 1'b0;
         sel_last_q  <= '0;
         smp_cnt_q   <= '0;
         disp_q      <= '0;
         reg_addr_q  <= '0;
         dmem_addr_q <= '0;
         imem_addr_q <= '0;
         ref_cnt_q   <= '0;
         dig_idx_q   <= '0;
         an_q        <= '1;
         seg_q       <= SEG_BLANK;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         wait_cnt_q  <= wait_cnt_d;
         pending_q   <= pending_d;
         sel_last_q  <= sel_last_d;
         smp_cnt_q   <= smp_cnt_d;
         disp_q      <= disp_d;
         reg_addr_q  <= reg_addr_d;
         dmem_addr_q <= dmem_addr_d;
         imem_addr_q <= imem_addr_d;
         ref_cnt_q   <= ref_cnt_d;
         dig_idx_q   <= dig_idx_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign led                 = LED_W'(sw_deb);
   assign seg                 = seg_q;
   assign an                  = an_q;
   assign dbg.debug_enable    = sw_deb[SW_W-3];
   assign dbg.reg_debug_addr  = reg_addr_q;
   assign dbg.dmem_debug_addr = dmem_addr_q;
   assign dbg.imem_debug_addr = imem_addr_q;

endmodule
